fan_link_tx: RTL and testbench
==============================

// Module: fan_link_tx
// PURPOSE
//  Host-side transmitter for the fan controller's 8-bit parallel config/sample link (data[7:0], strobe, config).
//  Queues one setpoint byte and one ADC sample byte from local producers and serialises them into framed bus cycles.
//  Each frame is setup -> strobe -> hold, timed for a receiver that latches data on every clk while strobe is high.
//  Sits on the test/host FPGA and drives the controller's ui_in / uio_in[0] / uio_in[1] pins.
// PARAMETERS
//  SETUP_CYC  2  clk cycles data/cfg are stable with strobe low before strobe rises; legal range 1..15
//  STRB_CYC   1  clk cycles strobe is held high; legal range 1..15
//  HOLD_CYC   1  clk cycles data/cfg are held with strobe low after strobe falls; legal range 1..15
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  reset, synchronous, active-low
//  en          in   1  1 = frames may start; 0 = no new frame starts, a frame in flight completes
//  set_valid   in   1  setpoint byte offered
//  set_data    in   8  setpoint value
//  set_ready   out  1  setpoint buffer free; a byte is accepted when set_valid & set_ready
//  adc_valid   in   1  ADC sample offered; always accepted
//  adc_data    in   8  ADC sample value
//  adc_drop    out  1  1-cycle pulse: pending unsent sample overwritten
//  bus_data    out  8  link data byte
//  bus_strb    out  1  link strobe, active high
//  bus_cfg     out  1  1 = setpoint frame, 0 = ADC frame
//  busy        out  1  state != IDLE
//  frame_done  out  1  1-cycle pulse on HOLD -> IDLE
// BEHAVIOUR
//  Reset: state IDLE; bus_data 0, bus_strb 0, bus_cfg 0, busy 0, frame_done 0, adc_drop 0; both pend flags 0, so set_ready 1.
//  A reset asserted mid-frame takes effect at the next edge: strobe drops and the frame is discarded.
//  Buffers:
//   - set_buf: one entry; set_ready = !set_pend.
//   - adc_buf: one entry, latest sample wins. adc_valid while adc_pend and the entry is not consumed in the same edge -> overwrite + adc_drop.
//  FSM states IDLE, SETUP, STROBE, HOLD. A 4-bit counter cnt reloads on each state entry.
//   - IDLE & en & set_pend: -> SETUP; bus_data <= set_buf, bus_cfg <= 1, set_pend <= 0.
//   - else IDLE & en & adc_pend: -> SETUP; bus_data <= adc_buf, bus_cfg <= 0, adc_pend <= 0.
//   - SETUP lasts SETUP_CYC cycles (strobe 0), then -> STROBE.
//   - STROBE lasts STRB_CYC cycles (bus_strb 1), then -> HOLD.
//   - HOLD lasts HOLD_CYC cycles (strobe 0), then -> IDLE with frame_done pulse.
//   - Setpoint has strict priority over ADC. At least 1 IDLE cycle separates frames.
//  bus_data/bus_cfg change only on the IDLE -> SETUP load and keep their value in IDLE. All outputs are registered.
//  Latency: valid sampled at edge k -> pend at k -> load at edge k+1 -> strobe high from edge k+1+SETUP_CYC.
//  Simultaneous load and write to the same buffer: the FSM takes the old contents; the new byte is stored and pend stays 1; no adc_drop.
//  Frame period = SETUP_CYC + STRB_CYC + HOLD_CYC + 1 clk.
//  en=0: pend flags and buffers keep accepting; only frame start is blocked.
// TESTING
//  1 Reset, then adc_valid 1 cycle with 0x5A (defaults) -> bus_data 0x5A, bus_cfg 0 at k+1; strobe high exactly 1 cycle at k+3; frame_done at k+5.
//  2 set 0xC3 and adc 0x11 offered in the same cycle -> set frame (cfg 1, 0xC3) first, then ADC frame 0x11 after one IDLE gap; set_ready low for 1 cycle only.
//  3 adc 0x01, 0x02, 0x03 on consecutive cycles during a running frame -> one adc_drop pulse per overwrite; next frame carries 0x03.
//  4 en=0 with both buffers pending -> no strobe for 20 cycles; en=1 -> set frame, then ADC frame.
//  5 rst_n low during STROBE -> bus_strb 0 after the next edge, all outputs at reset values, no frame_done.
//  6 SETUP_CYC=3, STRB_CYC=4, HOLD_CYC=2 -> strobe high 4 cycles; data stable 9 cycles; back-to-back frame period 10 cycles.

Source files
------------

// File: rtl/fan_link_tx_if.sv
// Producer/link signal bundle for fan_link_tx; master = host-side producers and observers, slave = the transmitter.
interface fan_link_tx_if;
    logic       en;
    logic       set_valid;
    logic [7:0] set_data;
    logic       set_ready;
    logic       adc_valid;
    logic [7:0] adc_data;
    logic       adc_drop;
    logic [7:0] bus_data;
    logic       bus_strb;
    logic       bus_cfg;
    logic       busy;
    logic       frame_done;

    modport master (
        output en, set_valid, set_data, adc_valid, adc_data,
        input  set_ready, adc_drop, bus_data, bus_strb, bus_cfg, busy, frame_done
    );

    modport slave (
        input  en, set_valid, set_data, adc_valid, adc_data,
        output set_ready, adc_drop, bus_data, bus_strb, bus_cfg, busy, frame_done
    );
endinterface

// File: rtl/fan_link_tx.sv
// Frames one queued setpoint byte or latest ADC sample onto the 8-bit link as setup/strobe/hold; load 1 clk after pend, strobe SETUP_CYC later.
// Setpoint uses valid/ready (one-entry buffer); ADC is never stalled, latest sample overwrites a pending one and pulses adc_drop.
module fan_link_tx #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned STRB_CYC  = 1,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fan_link_tx_if.slave  lnk
);
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STRB_LD  = 4'(STRB_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       set_pend;
    logic       adc_pend;
    logic [7:0] set_buf;
    logic [7:0] adc_buf;
    logic       adc_drop_r;
    logic [7:0] bus_data_r;
    logic       bus_strb_r;
    logic       bus_cfg_r;
    logic       busy_r;
    logic       frame_done_r;

    logic load_set;
    logic load_adc;
    logic set_wr;

    always_comb begin
        load_set = (state == IDLE) && lnk.en && set_pend;
        load_adc = (state == IDLE) && lnk.en && !set_pend && adc_pend;
        set_wr   = lnk.set_valid && !set_pend;
    end

    // A load and a write to the ADC buffer in the same edge keep pend set:
    // the FSM takes the old byte, the new one waits for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_pend   <= 1'b0;
            set_buf    <= 8'h00;
            adc_pend   <= 1'b0;
            adc_buf    <= 8'h00;
            adc_drop_r <= 1'b0;
        end else begin
            if (set_wr) begin
                set_buf  <= lnk.set_data;
                set_pend <= 1'b1;
            end else if (load_set) begin
                set_pend <= 1'b0;
            end

            if (lnk.adc_valid) begin
                adc_buf  <= lnk.adc_data;
                adc_pend <= 1'b1;
            end else if (load_adc) begin
                adc_pend <= 1'b0;
            end

            adc_drop_r <= lnk.adc_valid && adc_pend && !load_adc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            bus_data_r   <= 8'h00;
            bus_strb_r   <= 1'b0;
            bus_cfg_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_set) begin
                        state      <= SETUP;
                        cnt        <= SETUP_LD;
                        bus_data_r <= set_buf;
                        bus_cfg_r  <= 1'b1;
                        busy_r     <= 1'b1;
                    end else if (load_adc) begin
                        state      <= SETUP;
                        cnt        <= SETUP_LD;
                        bus_data_r <= adc_buf;
                        bus_cfg_r  <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        state      <= STROBE;
                        cnt        <= STRB_LD;
                        bus_strb_r <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        state      <= HOLD;
                        cnt        <= HOLD_LD;
                        bus_strb_r <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        state        <= IDLE;
                        cnt          <= 4'd0;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lnk.set_ready  = !set_pend;
    assign lnk.adc_drop   = adc_drop_r;
    assign lnk.bus_data   = bus_data_r;
    assign lnk.bus_strb   = bus_strb_r;
    assign lnk.bus_cfg    = bus_cfg_r;
    assign lnk.busy       = busy_r;
    assign lnk.frame_done = frame_done_r;
endmodule

// File: tb/tb_fan_link_tx.sv
// Directed bench for fan_link_tx: default timing instance plus a 3/4/2 timing instance.
module tb_fan_link_tx;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fan_link_tx_if a ();
    fan_link_tx_if b ();

    fan_link_tx dut_a (.clk(clk), .rst_n(rst_n), .lnk(a));
    fan_link_tx #(.SETUP_CYC(3), .STRB_CYC(4), .HOLD_CYC(2)) dut_b (.clk(clk), .rst_n(rst_n), .lnk(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int strobes;
        int busy_seen;
        int fd;
        int hi;
        int r1;
        int r2;
        int stable;
        logic prev;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a.en = 1'b1; a.set_valid = 1'b0; a.set_data = 8'h00; a.adc_valid = 1'b0; a.adc_data = 8'h00;
        b.en = 1'b1; b.set_valid = 1'b0; b.set_data = 8'h00; b.adc_valid = 1'b0; b.adc_data = 8'h00;
        repeat (2) tick();

        // reset state
        check("rst_bus_data", 32'(a.bus_data), 32'h00);
        check("rst_bus_strb", 32'(a.bus_strb), 32'h0);
        check("rst_bus_cfg", 32'(a.bus_cfg), 32'h0);
        check("rst_busy", 32'(a.busy), 32'h0);
        check("rst_frame_done", 32'(a.frame_done), 32'h0);
        check("rst_adc_drop", 32'(a.adc_drop), 32'h0);
        check("rst_set_ready", 32'(a.set_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        // 1: single ADC frame, default timing
        a.adc_valid = 1'b1; a.adc_data = 8'h5A;
        tick();
        a.adc_valid = 1'b0;
        check("t1_k_data", 32'(a.bus_data), 32'h00);
        check("t1_k_busy", 32'(a.busy), 32'h0);
        tick();
        check("t1_k1_data", 32'(a.bus_data), 32'h5A);
        check("t1_k1_cfg", 32'(a.bus_cfg), 32'h0);
        check("t1_k1_busy", 32'(a.busy), 32'h1);
        check("t1_k1_strb", 32'(a.bus_strb), 32'h0);
        tick();
        check("t1_k2_strb", 32'(a.bus_strb), 32'h0);
        tick();
        check("t1_k3_strb", 32'(a.bus_strb), 32'h1);
        tick();
        check("t1_k4_strb", 32'(a.bus_strb), 32'h0);
        check("t1_k4_done", 32'(a.frame_done), 32'h0);
        tick();
        check("t1_k5_done", 32'(a.frame_done), 32'h1);
        check("t1_k5_busy", 32'(a.busy), 32'h0);
        tick();
        check("t1_k6_done", 32'(a.frame_done), 32'h0);
        check("t1_k6_data_kept", 32'(a.bus_data), 32'h5A);

        // 2: setpoint priority over ADC, load/write collision on ADC buffer
        a.set_valid = 1'b1; a.set_data = 8'hC3; a.adc_valid = 1'b1; a.adc_data = 8'h11;
        tick();
        a.set_valid = 1'b0; a.adc_valid = 1'b0;
        check("t2_k_set_ready", 32'(a.set_ready), 32'h0);
        tick();
        check("t2_k1_set_ready", 32'(a.set_ready), 32'h1);
        check("t2_k1_data", 32'(a.bus_data), 32'hC3);
        check("t2_k1_cfg", 32'(a.bus_cfg), 32'h1);
        repeat (2) tick();
        check("t2_k3_strb", 32'(a.bus_strb), 32'h1);
        repeat (2) tick();
        check("t2_k5_done", 32'(a.frame_done), 32'h1);
        check("t2_k5_cfg_kept", 32'(a.bus_cfg), 32'h1);
        a.adc_valid = 1'b1; a.adc_data = 8'h22;
        tick();
        a.adc_valid = 1'b0;
        check("t2_k6_data", 32'(a.bus_data), 32'h11);
        check("t2_k6_cfg", 32'(a.bus_cfg), 32'h0);
        check("t2_k6_no_drop", 32'(a.adc_drop), 32'h0);
        repeat (5) tick();
        check("t2_k11_data", 32'(a.bus_data), 32'h22);
        check("t2_k11_busy", 32'(a.busy), 32'h1);
        repeat (5) tick();

        // 3: overwrites during a running frame
        a.adc_valid = 1'b1; a.adc_data = 8'hAA;
        tick();
        a.adc_valid = 1'b0;
        tick();
        check("t3_k1_data", 32'(a.bus_data), 32'hAA);
        a.adc_valid = 1'b1; a.adc_data = 8'h01;
        tick();
        check("t3_k2_drop", 32'(a.adc_drop), 32'h0);
        a.adc_data = 8'h02;
        tick();
        check("t3_k3_drop", 32'(a.adc_drop), 32'h1);
        a.adc_data = 8'h03;
        tick();
        check("t3_k4_drop", 32'(a.adc_drop), 32'h1);
        a.adc_valid = 1'b0;
        tick();
        check("t3_k5_drop", 32'(a.adc_drop), 32'h0);
        check("t3_k5_done", 32'(a.frame_done), 32'h1);
        tick();
        check("t3_k6_data", 32'(a.bus_data), 32'h03);
        repeat (5) tick();

        // 4: en low blocks frame start but buffers still fill
        a.en = 1'b0;
        a.set_valid = 1'b1; a.set_data = 8'h7E; a.adc_valid = 1'b1; a.adc_data = 8'h33;
        tick();
        a.set_valid = 1'b0; a.adc_valid = 1'b0;
        strobes = 0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a.bus_strb) strobes++;
            if (a.busy) busy_seen++;
        end
        check("t4_no_strobe", 32'(strobes), 32'd0);
        check("t4_no_busy", 32'(busy_seen), 32'd0);
        check("t4_set_ready", 32'(a.set_ready), 32'h0);
        a.en = 1'b1;
        tick();
        check("t4_e_data", 32'(a.bus_data), 32'h7E);
        check("t4_e_cfg", 32'(a.bus_cfg), 32'h1);
        repeat (5) tick();
        check("t4_e6_data", 32'(a.bus_data), 32'h33);
        check("t4_e6_cfg", 32'(a.bus_cfg), 32'h0);
        repeat (5) tick();

        // 5: reset during STROBE discards the frame
        a.adc_valid = 1'b1; a.adc_data = 8'h44;
        tick();
        a.adc_valid = 1'b0;
        repeat (3) tick();
        check("t5_strb_hi", 32'(a.bus_strb), 32'h1);
        rst_n = 1'b0;
        tick();
        check("t5_strb", 32'(a.bus_strb), 32'h0);
        check("t5_busy", 32'(a.busy), 32'h0);
        check("t5_data", 32'(a.bus_data), 32'h00);
        check("t5_cfg", 32'(a.bus_cfg), 32'h0);
        check("t5_done", 32'(a.frame_done), 32'h0);
        check("t5_set_ready", 32'(a.set_ready), 32'h1);
        rst_n = 1'b1;
        fd = 0;
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a.frame_done) fd++;
            if (a.busy) busy_seen++;
        end
        check("t5_no_done", 32'(fd), 32'd0);
        check("t5_no_restart", 32'(busy_seen), 32'd0);

        // 6: SETUP 3 / STRB 4 / HOLD 2, back-to-back set then ADC frame
        b.set_valid = 1'b1; b.set_data = 8'h66; b.adc_valid = 1'b1; b.adc_data = 8'h9C;
        tick();
        b.set_valid = 1'b0; b.adc_valid = 1'b0;
        hi = 0; r1 = 0; r2 = 0; stable = 0; prev = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (b.bus_strb) hi++;
            if (b.bus_strb && !prev) begin
                if (r1 == 0) r1 = i;
                else if (r2 == 0) r2 = i;
            end
            if (b.busy && b.bus_cfg && b.bus_data == 8'h66) stable++;
            prev = b.bus_strb;
        end
        check("t6_strobe_cycles", 32'(hi), 32'd8);
        check("t6_first_rise", 32'(r1), 32'd4);
        check("t6_period", 32'(r2 - r1), 32'd10);
        check("t6_data_stable", 32'(stable), 32'd9);
        check("t6_second_data", 32'(b.bus_data), 32'h9C);
        check("t6_idle", 32'(b.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
